md_issue_ctrl: RTL and testbench



---
 rtl/md_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_md_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage initiator side of the multiply/divide unit handshake.
// Issues a one-cycle start, tracks the outstanding op and stalls HI/LO users in D.
module md_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned SLACK       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] instr_e,
  input  logic        valid_e,
  input  logic        flush_e,
  input  logic        md_busy,
  output logic        md_start,
  output logic        stall_d,
  output logic        proto_err,
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned LW      = $clog2(MAX_CYC + 1);
  localparam int unsigned SW      = $clog2(SLACK + 2);

  localparam logic [LW-1:0] MULT_LAT  = LW'(MULT_CYCLES - 1);
  localparam logic [LW-1:0] DIV_LAT   = LW'(DIV_CYCLES - 1);
  localparam logic [SW-1:0] SLACK_LIM = SW'(SLACK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic logic f_is_md(input logic [5:0] op, input logic [5:0] funct);
    return (op == 6'd0) && (funct[5:2] == 4'b0110);
  endfunction

  function automatic logic f_is_hilo(input logic [5:0] op, input logic [5:0] funct);
    return (op == 6'd0) && ((funct[5:2] == 4'b0110) || (funct[5:2] == 4'b0100));
  endfunction

  state_e          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   slack_q, slack_d;
  logic            err_q, err_d;
  logic [31:0]     issue_q, issue_d;
  logic [31:0]     stall_q, stall_d_cnt;

  logic md_op_e_s;
  logic div_e_s;
  logic hilo_d_s;
  logic start_s;
  logic stall_s;
  logic unused_instr_s;

  assign md_op_e_s      = f_is_md(instr_e[31:26], instr_e[5:0]);
  assign div_e_s        = instr_e[1];
  assign hilo_d_s       = f_is_hilo(instr_d[31:26], instr_d[5:0]);
  assign unused_instr_s = ^{instr_d[25:6], instr_e[25:6]};

  // Start is gated by reset so nothing reaches the MDU while the pipeline restarts.
  always_comb begin
    start_s = ~reset & valid_e & ~flush_e & md_op_e_s & (state_q == IDLE);
    stall_s = hilo_d_s & (start_s | (state_q != IDLE));
  end

  assign md_start  = start_s;
  assign stall_d   = stall_s;
  assign proto_err = err_q;
  assign issue_cnt = issue_q;
  assign stall_cnt = stall_q;

  // Next-state, shadow latency/slack tracking and protocol checks.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    slack_d     = slack_q;
    err_d       = err_q;
    issue_d     = start_s ? (issue_q + 32'd1) : issue_q;
    stall_d_cnt = stall_s ? (stall_q + 32'd1) : stall_q;

    // A stalled pipeline always bubbles E, so an md_op seen here is a held instruction.
    if ((state_q != IDLE) && valid_e && md_op_e_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = ISSUE;
          lat_d   = div_e_s ? DIV_LAT : MULT_LAT;
          slack_d = {SW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (md_busy) begin
          state_d = WAIT;
          lat_d   = (lat_q == {LW{1'b0}}) ? {LW{1'b0}} : (lat_q - LW'(1));
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (md_busy) begin
          if (lat_q != {LW{1'b0}}) begin
            lat_d = lat_q - LW'(1);
          end else if (slack_q == SLACK_LIM) begin
            err_d = 1'b1;
          end else begin
            slack_d = slack_q + SW'(1);
          end
        end else begin
          state_d = IDLE;
          slack_d = {SW{1'b0}};
          if (lat_q > LW'(1)) begin
            err_d = 1'b1;
          end else begin
            lat_d = lat_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= {LW{1'b0}};
      slack_q <= {SW{1'b0}};
      err_q   <= 1'b0;
      issue_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      slack_q <= slack_d;
      err_q   <= err_d;
      issue_q <= issue_d;
      stall_q <= stall_d_cnt;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: decode table, directed multi-cycle sequences and
// randomized traffic compared against a cycle-count based reference model.
module tb_md_issue_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int SLACK       = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d, instr_e;
  logic        valid_e, flush_e, md_busy;
  logic        md_start, stall_d, proto_err;
  logic [31:0] issue_cnt, stall_cnt;

  md_issue_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .SLACK(SLACK)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
    .valid_e(valid_e), .flush_e(flush_e), .md_busy(md_busy),
    .md_start(md_start), .stall_d(stall_d), .proto_err(proto_err),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an op is outstanding from the cycle after its start until
  // the first cycle (k>=1 after start) that sees busy low.
  bit          m_out = 1'b0;
  int          m_t0  = 0;
  int          m_lat = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_issue = 32'd0;
  logic [31:0] m_stall = 32'd0;
  int          cyc = 0;
  bit          primed = 1'b0;
  bit          e_start, e_stall;
  logic        s_start, s_stall;

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'd0, fn};
  endfunction

  function automatic bit f_md(input logic [31:0] i);
    return (i[31:26] == 6'd0) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
  endfunction

  function automatic bit f_hilo(input logic [31:0] i);
    return f_md(i) || ((i[31:26] == 6'd0) && (i[5:0] >= 6'h10) && (i[5:0] <= 6'h13));
  endfunction

  function automatic int f_len(input logic [31:0] i);
    return (i[5:0] >= 6'h1A) ? DIV_CYCLES : MULT_CYCLES;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fn;
    case ($urandom_range(0, 5))
      0: fn = 6'(6'h18 + $urandom_range(0, 3));
      1: fn = 6'(6'h10 + $urandom_range(0, 3));
      2: fn = 6'($urandom_range(0, 63));
      default: fn = 6'h20;
    endcase
    if ($urandom_range(0, 5) == 0) return {6'($urandom_range(1, 63)), 20'($urandom), fn};
    return {6'd0, 20'($urandom), fn};
  endfunction

  function automatic int pick_dur(input logic [31:0] i);
    int n;
    n = f_len(i);
    case ($urandom_range(0, 19))
      0: return 0;
      1: return n - 1 + SLACK + 2;
      2: return n - 3;
      3: return n - 2;
      default: return n - 1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance model, return after posedge.
  task automatic cycle(input bit r, input logic [31:0] d, input logic [31:0] e,
                       input bit v, input bit f, input bit b);
    int k;
    reset = r; instr_d = d; instr_e = e; valid_e = v; flush_e = f; md_busy = b;
    @(negedge clk);
    e_start = !r && v && !f && f_md(e) && !m_out;
    e_stall = f_hilo(d) && (e_start || m_out);
    s_start = md_start;
    s_stall = stall_d;
    chk("md_start", {31'd0, md_start}, {31'd0, e_start});
    chk("stall_d", {31'd0, stall_d}, {31'd0, e_stall});
    if (primed) begin
      chk("proto_err", {31'd0, proto_err}, {31'd0, m_err});
      chk("issue_cnt", issue_cnt, m_issue);
      chk("stall_cnt", stall_cnt, m_stall);
    end
    if (r) begin
      m_out = 1'b0; m_err = 1'b0; m_issue = 32'd0; m_stall = 32'd0; primed = 1'b1;
    end else begin
      if (m_out) begin
        k = cyc - m_t0;
        if (v && f_md(e)) m_err = 1'b1;
        if (!b) begin
          if ((k == 1) || (k < m_lat - 1)) m_err = 1'b1;
          m_out = 1'b0;
        end else if ((k >= 2) && (k >= m_lat + SLACK)) begin
          m_err = 1'b1;
        end
      end
      if (e_start) begin
        m_out = 1'b1; m_t0 = cyc; m_lat = f_len(e);
      end
      m_issue = m_issue + {31'd0, e_start};
      m_stall = m_stall + {31'd0, e_stall};
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] d;
    logic [31:0] e;
    bit          v;
    bit          f;
    bit          xs;
    bit          xt;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] NOP, MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO, MTLO;
  logic [31:0] d_q, e_q;
  bit          v_q, r, f, b, hold;
  int          busy_left, cnt, nst, t_a, t_b;

  initial begin
    NOP  = 32'd0;        MULT = ri(6'd0, 6'h18); MULTU = ri(6'd0, 6'h19);
    DIV  = ri(6'd0, 6'h1A); DIVU = ri(6'd0, 6'h1B);
    MFHI = ri(6'd0, 6'h10); MTHI = ri(6'd0, 6'h11);
    MFLO = ri(6'd0, 6'h12); MTLO = ri(6'd0, 6'h13);

    tbl[0] = '{1'b0, MFHI, NOP, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, MTHI, MULT, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, MFLO, MULT, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, MTLO, DIVU, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, ri(6'd0, 6'h20), DIV, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, ri(6'h23, 6'h10), MULTU, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, MULT, ri(6'h02, 6'h18), 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, MULT, MULT, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, DIVU, DIVU, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, ri(6'd0, 6'h14), ri(6'd0, 6'h1C), 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; instr_d = NOP; instr_e = NOP; valid_e = 1'b0; flush_e = 1'b0; md_busy = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, NOP, NOP, 0, 0, 0);
    chk("reset_issue", issue_cnt, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_err", {31'd0, proto_err}, 32'd0);

    // Decode table, each vector applied from a freshly reset IDLE state.
    for (int i = 0; i < 10; i++) begin
      cycle(1, NOP, NOP, 0, 0, 0);
      cycle(tbl[i].rst, tbl[i].d, tbl[i].e, tbl[i].v, tbl[i].f, 0);
      chk($sformatf("tbl%0d_start", i), {31'd0, s_start}, {31'd0, tbl[i].xs});
      chk($sformatf("tbl%0d_stall", i), {31'd0, s_stall}, {31'd0, tbl[i].xt});
    end

    // mult with MDU busy for MULTCYCLES-1 cycles, mfhi waiting in D.
    cycle(1, NOP, NOP, 0, 0, 0);
    cnt = 0;
    cycle(0, MFHI, MULT, 1, 0, 0); cnt += int'(s_start);
    for (int i = 1; i < MULT_CYCLES; i++) begin cycle(0, MFHI, NOP, 0, 0, 1); cnt += int'(s_start); end
    cycle(0, MFHI, NOP, 0, 0, 0); cnt += int'(s_start);
    cycle(0, MFHI, NOP, 0, 0, 0); cnt += int'(s_start);
    chk("t1_start_pulses", cnt, 32'd1);
    chk("t1_released", {31'd0, s_stall}, 32'd0);
    chk("t1_issue_cnt", issue_cnt, 32'd1);
    chk("t1_stall_cnt", stall_cnt, 32'd6);
    chk("t1_err", {31'd0, proto_err}, 32'd0);

    // divu then mflo in D: stalled from ISSUE through the busy-fall cycle.
    cycle(1, NOP, NOP, 0, 0, 0);
    nst = 0;
    cycle(0, NOP, DIVU, 1, 0, 0);
    for (int i = 1; i < DIV_CYCLES; i++) begin cycle(0, MFLO, NOP, 0, 0, 1); nst += int'(s_stall); end
    cycle(0, MFLO, NOP, 0, 0, 0); nst += int'(s_stall);
    cycle(0, MFLO, NOP, 0, 0, 0);
    chk("t2_stall_cycles", nst, 32'd10);
    chk("t2_released", {31'd0, s_stall}, 32'd0);
    chk("t2_stall_cnt", stall_cnt, 32'd10);

    // mult immediately followed by div: div held in D, issues once IDLE.
    cycle(1, NOP, NOP, 0, 0, 0);
    d_q = DIV; e_q = MULT; v_q = 1'b1; busy_left = 0; t_a = -1; t_b = -1;
    for (int n = 0; n < 20; n++) begin
      b = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      cycle(0, d_q, e_q, v_q, 0, b);
      if (s_start) begin
        if (t_a < 0) t_a = n; else t_b = n;
        busy_left = f_len(e_q) - 1;
      end
      if (s_stall) v_q = 1'b0;
      else begin e_q = d_q; v_q = 1'b1; d_q = NOP; end
    end
    chk("t3_first_start", t_a, 32'd0);
    chk("t3_gap", t_b - t_a, MULT_CYCLES + 2);
    chk("t3_issue_cnt", issue_cnt, 32'd2);

    // Flushed or invalid md_op never starts; state remains IDLE.
    cycle(1, NOP, NOP, 0, 0, 0);
    cycle(0, NOP, MULT, 1, 1, 0);
    chk("t4_flush", {31'd0, s_start}, 32'd0);
    cycle(0, NOP, MULT, 0, 0, 0);
    chk("t4_invalid", {31'd0, s_start}, 32'd0);
    chk("t4_issue_cnt", issue_cnt, 32'd0);
    cycle(0, NOP, MULT, 1, 0, 0);
    chk("t4_still_idle", {31'd0, s_start}, 32'd1);

    // MDU never raises busy.
    cycle(1, NOP, NOP, 0, 0, 0);
    cycle(0, NOP, MULT, 1, 0, 0);
    chk("t5_err_pre", {31'd0, proto_err}, 32'd0);
    cycle(0, NOP, NOP, 0, 0, 0);
    chk("t5_no_busy", {31'd0, proto_err}, 32'd1);

    // Busy overrun beyond latency plus slack, then reset clears everything.
    cycle(1, NOP, NOP, 0, 0, 0);
    cycle(0, NOP, MULT, 1, 0, 0);
    for (int i = 0; i < MULT_CYCLES + SLACK + 1; i++) cycle(0, NOP, NOP, 0, 0, 1);
    cycle(0, NOP, NOP, 0, 0, 0);
    chk("t5_overrun", {31'd0, proto_err}, 32'd1);
    cycle(1, NOP, NOP, 0, 0, 0);
    chk("t5_rst_err", {31'd0, proto_err}, 32'd0);
    chk("t5_rst_issue", issue_cnt, 32'd0);

    // Reset in the third WAIT cycle of a div with mthi in D.
    cycle(1, NOP, NOP, 0, 0, 0);
    cycle(0, MTHI, DIV, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, MTHI, NOP, 0, 0, 1);
    cycle(1, MTHI, NOP, 0, 0, 1);
    cycle(0, MTHI, NOP, 0, 0, 1);
    chk("t6_stall", {31'd0, s_stall}, 32'd0);
    chk("t6_start", {31'd0, s_start}, 32'd0);
    chk("t6_issue", issue_cnt, 32'd0);
    chk("t6_stall_cnt", stall_cnt, 32'd0);
    chk("t6_err", {31'd0, proto_err}, 32'd0);

    // Randomized traffic with an MDU that sometimes misbehaves.
    cycle(1, NOP, NOP, 0, 0, 0);
    d_q = rnd_instr(); e_q = NOP; v_q = 1'b0; busy_left = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 9) == 0);
      b = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      cycle(r, d_q, e_q, v_q, f, b);
      if (s_start) busy_left = pick_dur(e_q);
      hold = v_q && f_md(e_q) && ($urandom_range(0, 29) == 0);
      if (r) begin
        d_q = rnd_instr(); v_q = 1'b0;
      end else if (e_stall) begin
        v_q = 1'b0;
      end else if (!hold) begin
        e_q = d_q; v_q = ($urandom_range(0, 9) != 0); d_q = rnd_instr();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
